// File: rtl/reg_scan_disp_if.sv
// Debug-display bus: mode/freeze controls, CPU register-file debug port and 8-digit segment outputs.
// The master side drives controls and register data; the slave (display) side drives reg_sel and the segments.
interface reg_scan_disp_if;
  logic        auto_en;
  logic [4:0]  manual_sel;
  logic        freeze;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  modport master (
    output auto_en, manual_sel, freeze, reg_data,
    input  reg_sel, seg_an, seg_out
  );

  modport slave (
    input  auto_en, manual_sel, freeze, reg_data,
    output reg_sel, seg_an, seg_out
  );
endinterface

// File: rtl/reg_scan_disp.sv
// Scans a CPU register word onto an 8-digit multiplexed hex display, auto-stepping or manually selecting the register.
// Latency: reg_sel 1 cycle after its cause, display word 1 cycle behind reg_sel, segments 1 cycle behind digit/word.
// No backpressure: reg_data is assumed valid combinationally for whatever reg_sel presents.
module reg_scan_disp #(
  parameter int SCAN_DIV = 50000,
  parameter int STEP_DIV = 100000000
) (
  input  logic           clk,
  input  logic           rst,
  reg_scan_disp_if.slave bus
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int STEP_W = $clog2(STEP_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic [SCAN_W-1:0] scan_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic              scan_tick;
  logic              step_tick;
  logic [2:0]        digit;
  logic [4:0]        reg_sel_q;
  logic [31:0]       disp_word;
  logic [3:0]        nibble;
  logic [6:0]        seg7;
  logic              dp_n;
  logic [7:0]        seg_an_q;
  logic [7:0]        seg_out_q;

  assign scan_tick = (scan_cnt == SCAN_LAST);
  assign step_tick = bus.auto_en && (step_cnt == STEP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= '0;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
      if (scan_tick) begin
        digit <= digit + 3'd1;
      end
    end
  end

  // Step counter only runs in auto mode, so re-entering auto always waits a full STEP_DIV.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt  <= '0;
      reg_sel_q <= '0;
    end else if (!bus.auto_en) begin
      step_cnt  <= '0;
      reg_sel_q <= bus.manual_sel;
    end else begin
      step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
      if (step_tick) begin
        reg_sel_q <= reg_sel_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_word <= '0;
    end else if (!bus.freeze) begin
      disp_word <= bus.reg_data;
    end
  end

  assign nibble = disp_word[{digit, 2'b00} +: 4];
  assign dp_n   = ~(bus.auto_en && (digit == 3'd7));

  always_comb begin
    seg7 = 7'b1111111;
    case (nibble)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      4'hF: seg7 = 7'b0001110;
      default: seg7 = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_an_q  <= 8'hFF;
      seg_out_q <= 8'hFF;
    end else begin
      seg_an_q  <= ~(8'b0000_0001 << digit);
      seg_out_q <= {dp_n, seg7};
    end
  end

  assign bus.reg_sel = reg_sel_q;
  assign bus.seg_an  = seg_an_q;
  assign bus.seg_out = seg_out_q;

endmodule

// File: tb/tb_reg_scan_disp.sv
// Directed bench for reg_scan_disp with a register-file model and an expected-value queue.
module tb_reg_scan_disp;
  localparam int SCAN_DIV = 4;
  localparam int STEP_DIV = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_scan_disp_if dif ();
  logic [31:0] rf [32];
  assign dif.reg_data = rf[dif.reg_sel];

  reg_scan_disp #(.SCAN_DIV(SCAN_DIV), .STEP_DIV(STEP_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  int          errors = 0;
  int          checks = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    tag = tag_q.pop_front();
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_an(input logic [7:0] an, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (dif.seg_an === an) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic check_digit(input string tag, input int d, input logic [31:0] word, input logic dp);
    bit         ok;
    logic [7:0] an;
    an    = 8'hFF;
    an[d] = 1'b0;
    push(tag, {24'b0, dp, hex7(word[4*d +: 4])});
    wait_an(an, ok);
    if (!ok) chk('x);
    else     chk({24'b0, dif.seg_out});
  endtask

  task automatic check_word(input string tag, input logic [31:0] word, input logic dp7);
    for (int d = 0; d < 8; d++) begin
      check_digit(tag, d, word, (d == 7) ? dp7 : 1'b1);
    end
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog timeout");
  end

  initial begin
    bit ok;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h0101_0101;
    rf[7]          = 32'h1234_ABCD;
    rst            = 1'b1;
    dif.auto_en    = 1'b1;
    dif.manual_sel = 5'd0;
    dif.freeze     = 1'b0;

    // Reset state
    tick(2);
    push("rst_sel", 0);      chk({27'b0, dif.reg_sel});
    push("rst_an", 8'hFF);   chk({24'b0, dif.seg_an});
    push("rst_seg", 8'hFF);  chk({24'b0, dif.seg_out});

    // First scan tick lands SCAN_DIV cycles after release
    rst = 1'b0;
    push("an_e1", 8'hFE);   tick(1); chk({24'b0, dif.seg_an});
    push("an_e4", 8'hFE);   tick(3); chk({24'b0, dif.seg_an});
    push("an_e5", 8'hFD);   tick(1); chk({24'b0, dif.seg_an});
    push("sel_e15", 0);     tick(10); chk({27'b0, dif.reg_sel});
    push("sel_e16", 1);     tick(1); chk({27'b0, dif.reg_sel});

    // Auto stepping through all 32 registers with wrap; dp tracks digit 7
    for (int k = 2; k <= 32; k++) begin
      for (int c = 0; c < STEP_DIV; c++) begin
        tick(1);
        push("auto_dp", (dif.seg_an === 8'h7F) ? 32'd0 : 32'd1);
        chk({31'b0, dif.seg_out[7]});
      end
      push("auto_sel", 32'(k % 32));
      chk({27'b0, dif.reg_sel});
    end

    // Manual select latency and decode
    dif.auto_en    = 1'b0;
    dif.manual_sel = 5'd7;
    push("man_sel", 7); tick(1); chk({27'b0, dif.reg_sel});
    tick(2);
    check_word("man_word", 32'h1234_ABCD, 1'b1);

    // Freeze holds the word while reg_sel keeps following
    rf[7] = 32'hDEAD_BEEF;
    tick(3);
    check_word("pre_freeze", 32'hDEAD_BEEF, 1'b1);
    dif.freeze = 1'b1;
    rf[7]      = 32'h0;
    dif.manual_sel = 5'd3;
    push("frz_sel", 3); tick(1); chk({27'b0, dif.reg_sel});
    dif.manual_sel = 5'd7;
    tick(2);
    check_word("frozen", 32'hDEAD_BEEF, 1'b1);
    dif.freeze = 1'b0;
    tick(2);
    check_word("unfrozen", 32'h0, 1'b1);

    // Mode switch at step_cnt=9 must restart the step interval
    dif.auto_en = 1'b1;
    push("ms_a9", 7);  tick(9); chk({27'b0, dif.reg_sel});
    dif.auto_en    = 1'b0;
    dif.manual_sel = 5'd20;
    push("ms_man", 20); tick(1); chk({27'b0, dif.reg_sel});
    dif.auto_en = 1'b1;
    push("ms_b15", 20); tick(15); chk({27'b0, dif.reg_sel});
    push("ms_b16", 21); tick(1); chk({27'b0, dif.reg_sel});

    // Reset mid-operation with freeze asserted
    dif.auto_en    = 1'b0;
    dif.manual_sel = 5'd19;
    push("pre_rst_sel", 19); tick(1); chk({27'b0, dif.reg_sel});
    wait_an(8'hDF, ok);
    push("reach_digit5", 1); chk({31'b0, ok});
    dif.freeze = 1'b1;
    rst        = 1'b1;
    tick(1);
    push("mid_rst_sel", 0);     chk({27'b0, dif.reg_sel});
    push("mid_rst_an", 8'hFF);  chk({24'b0, dif.seg_an});
    push("mid_rst_seg", 8'hFF); chk({24'b0, dif.seg_out});
    rst = 1'b0;
    tick(1);
    push("post_rst_an", 8'hFE);  chk({24'b0, dif.seg_an});
    push("post_rst_seg", 8'hC0); chk({24'b0, dif.seg_out});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_scan_disp.md
REG_SCAN_DISP -- requirements
Module: reg_scan_disp

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit-scan tick (legal range >= 2).
REQ-002 SHALL have parameter STEP_DIV, default 100000000, clk cycles per auto register step (legal range >= 2).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port auto_en  input  1  1 = step through registers automatically; 0 = manual select.
REQ-006 SHALL have port manual_sel  input  5  register index shown when auto_en=0.
REQ-007 SHALL have port freeze  input  1  1 = hold the displayed word.
REQ-008 SHALL have port reg_sel  output  5  register index driven to the CPU register-file debug port.
REQ-009 SHALL have port reg_data  input  32  register contents returned combinationally by the CPU for reg_sel.
REQ-010 SHALL have port seg_an  output  8  digit enables, active-low, one-hot-zero.
REQ-011 SHALL have port seg_out  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-012 SHALL count scan_cnt 0..SCAN_DIV-1, wrapping to 0; scan_tick SHALL be a 1-cycle pulse when scan_cnt = SCAN_DIV-1.
REQ-013 SHALL count step_cnt 0..STEP_DIV-1 only while auto_en=1; step_tick SHALL pulse when step_cnt = STEP_DIV-1.
REQ-014 SHALL clear step_cnt to 0 in any cycle where auto_en=0.
REQ-015 SHALL, in auto mode, increment reg_sel by 1 on step_tick, with wrap 31 -> 0.
REQ-016 SHALL, in manual mode, load reg_sel <= manual_sel every cycle; 1-cycle latency.
REQ-017 SHALL, on an auto_en 0 -> 1 transition, continue auto stepping from the current reg_sel value.
REQ-018 SHALL capture disp_word <= reg_data every cycle while freeze=0; the display therefore lags reg_sel by exactly 1 cycle.
REQ-019 SHALL hold disp_word unchanged while freeze=1; reg_sel stepping SHALL continue regardless of freeze.
REQ-020 SHALL advance the 3-bit digit index on scan_tick, wrapping 7 -> 0.
REQ-021 SHALL drive seg_an low only on bit [digit index]; all other bits high.
REQ-022 SHALL decode the nibble disp_word[4*digit+3 : 4*digit] with the hex table 0-9, A, b, C, d, E, F (a-g, active-low), e.g. 0 -> 7'b1000000 for {g..a}, F -> 7'b0001110.
REQ-023 SHALL light dp (drive low) only on digit 7, and only while auto_en=1; otherwise dp SHALL be driven high.
REQ-024 SHALL register seg_an and seg_out, so they change 1 cycle after the digit index or disp_word changes.
REQ-025 SHALL treat simultaneous step_tick and scan_tick independently; neither SHALL delay the other.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set scan_cnt=0, step_cnt=0, digit=0, reg_sel=0, disp_word=0.
REQ-027 SHALL, on the same reset edge, set seg_an=8'hFF and seg_out=8'hFF (display blank).
REQ-028 SHALL give rst priority over every other input, including mid-count and while freeze=1.
REQ-029 SHALL leave the first scan_tick SCAN_DIV cycles after rst is released.

Verification (SCAN_DIV=4, STEP_DIV=16)
REQ-030 Reset: assert rst 2 cycles, auto_en=1 -> reg_sel=0, seg_an=FF, seg_out=FF; after release, first scan_tick at cycle 4, and seg_an=FE on the following cycle.
REQ-031 Auto wrap: auto_en=1, run 32*16 cycles -> reg_sel steps 0,1,...,31 every 16 cycles, then 0; dp low only while digit 7 is active.
REQ-032 Manual latency: auto_en=0, manual_sel=7, reg_data model returns 32'h1234ABCD for index 7 -> reg_sel=7 after 1 cycle, disp_word=1234ABCD after 2 cycles; digit 0 shows D (seg_out[6:0]=7'b0100001), digit 7 shows 1.
REQ-033 Freeze: freeze=1 with disp_word=DEADBEEF, then reg_data changes to 0 -> display still DEADBEEF; releasing freeze -> 00000000 after 1 cycle.
REQ-034 Mode switch mid-step: auto_en 1 -> 0 at step_cnt=9 -> step_cnt=0 next cycle; auto_en back to 1 -> next step occurs exactly 16 cycles later.
REQ-035 Reset mid-operation: rst at reg_sel=19, digit=5 -> all state returns to the reset values in REQ-026 and REQ-027 on the next edge.
